sha256_core_arbiter: RTL and testbench
======================================

# sha256_core_arbiter

Round-robin scheduler that shares one `simplified_sha256` core among `NUM_REQ` requesters. Each requester presents a job as a message address and an output address, and holds a level request. The arbiter grants one requester at a time, pulses the core's `start`, and waits for the core's `done`. It then returns a one-cycle completion pulse to the winner. A hung core is detected with a watchdog, reset through a dedicated core reset, and the job is reported as failed.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 16: address width; matches the core's `message_addr`/`output_addr`.
- `TIMEOUT_CYC`, 4096: watchdog limit in BUSY cycles; must be ≥ 2.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  level job request per requester.
- `req_msg_addr`  in  NUM_REQ*ADDR_W  message address; slice i belongs to requester i.
- `req_out_addr`  in  NUM_REQ*ADDR_W  hash output address; slice i belongs to requester i.
- `grant`  out  NUM_REQ  one-hot; high from job issue through completion.
- `req_done`  out  NUM_REQ  one-cycle pulse; the job completed.
- `req_err`  out  NUM_REQ  one-cycle pulse; the job was aborted by the watchdog.
- `busy`  out  1  high whenever state is not IDLE.
- `jobs_done`  out  16  count of completed jobs; wraps at 0xFFFF→0; aborted jobs are not counted.
- `core_start`  out  1  drives the core's `start`.
- `core_msg_addr`  out  ADDR_W  drives the core's `message_addr`.
- `core_out_addr`  out  ADDR_W  drives the core's `output_addr`.
- `core_done`  in  1  from the core's `done`; a one-cycle pulse.
- `core_rst_n`  out  1  core soft reset; the top level ANDs it with `reset_n` at the core.

## Operation
- States are IDLE, BUSY, RELEASE and RECOVER. All outputs are registered.
- **Reset values:**
  - state=IDLE.
  - `grant`, `req_done`, `req_err`, `core_start`, `core_msg_addr`, `core_out_addr`, `jobs_done`, timer and priority pointer `ptr` are all 0.
  - `busy`=0, `core_rst_n`=1.
- **IDLE:**
  - If any `req` bit is high, choose the winner w. It is the first set bit scanning from `ptr` upward, modulo NUM_REQ.
  - On that edge: set `grant`=1<<w, latch slice w of both address buses, set `core_start`=1, clear the timer, and go to BUSY.
  - If no `req` bit is high, remain in IDLE.
- **BUSY:**
  - `core_start` returns to 0 after exactly one cycle. The timer increments each cycle.
  - If `core_done`=1: set `req_done[w]`=1, increment `jobs_done`, go to RELEASE.
  - Else if timer==TIMEOUT_CYC-1: set `req_err[w]`=1 and `core_rst_n`=0, clear the timer, go to RECOVER.
  - If `core_done` arrives in the same cycle as the timeout, `core_done` wins.
- **RELEASE** (1 cycle):
  - `req_done` clears and `grant` clears.
  - Set `ptr`=(w+1) mod NUM_REQ, then go to IDLE.
- **RECOVER** (2 cycles):
  - `req_err` clears after its first cycle.
  - `core_rst_n` stays low for 2 cycles.
  - Then set `core_rst_n`=1, clear `grant`, advance `ptr` as in RELEASE, and go to IDLE.
- **Requester rules:**
  - The address slices must be stable while `req` is high and not yet granted.
  - Addresses are latched at grant; later changes are ignored.
  - A requester drops `req` on the edge where it samples `req_done` or `req_err`. Keeping `req` high requests a further job.
  - Dropping `req` while granted does not cancel the job; the completion pulse is still delivered.
- `core_done` seen in any state other than BUSY is ignored.
- Asserting `reset_n` mid-job returns to the reset values immediately. No pulse is issued for the in-flight job.

## Timing
- `req` rises → `core_start` and `grant` are high on the next cycle. Latency is 1 cycle.
- `core_done` pulse → `req_done` is high on the next cycle for exactly 1 cycle.
- Minimum spacing between `core_done` and the next `core_start` is 2 cycles (RELEASE, then IDLE). This guarantees the core is back in its IDLE state.
- Watchdog fires after TIMEOUT_CYC BUSY cycles. `core_rst_n` is low for exactly 2 cycles. Abort to the next grant is at minimum 3 cycles.
- Fairness: under continuous requests from all requesters, each is granted once per NUM_REQ jobs.

## Structure
- Package `sha256_ctrl_pkg` holds:
  - the state enum `arb_state_t`;
  - `DEFAULT_TIMEOUT_CYC`;
  - `CORE_RST_CYC` = 2.
- Sub-module `rr_picker` is combinational. Inputs are `req` and `ptr`; outputs are a one-hot winner and a valid flag. It is reusable by other shared-resource arbiters.

## Test plan
- **Single requester:** req[2]=1 with msg=0x0000, out=0x0100 → `core_start` is 1 cycle high with `core_msg_addr`=0x0000 and `core_out_addr`=0x0100. The model `core_done` arrives 150 cycles later → `req_done[2]` pulses 1 cycle later and `jobs_done`=1.
- **Round robin:** all `req` held high for 8 jobs → grant order is 0,1,2,3,0,1,2,3 and `jobs_done`=8.
- **Timeout:** TIMEOUT_CYC=16 with the core never asserting `done` → `req_err[w]` pulses at BUSY cycle 16 and `core_rst_n` is low for 2 cycles. The next requester is granted afterwards and `jobs_done` is unchanged.
- **Simultaneous events:**
  - `core_done` on cycle TIMEOUT_CYC-1 → `req_done` pulses, there is no `req_err`, and `core_rst_n` stays 1.
  - Requester 1 drops `req` mid-job → `req_done[1]` is still delivered.
- **Reset mid-BUSY:** `reset_n` pulsed low → all outputs return to reset values. After release, a pending `req[3]` is granted first with `ptr`=0, scanning 0..3.

Source files
------------

// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 core arbitration logic.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sha256_ctrl_pkg;

  // Arbiter FSM: wait for a request, run a job, cool down, or recover a hung core.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_t;

  // Watchdog limit used when the integrator does not override it.
  localparam int DEFAULT_TIMEOUT_CYC = 4096;

  // Number of cycles the core soft reset is held low after a watchdog abort.
  localparam int CORE_RST_CYC = 2;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the winner.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic               vld
);

  logic [PTR_W-1:0] idx;

  // Scan from ptr upward with wrap-around; the first hit wins.
  always_comb begin
    winner_oh = '0;
    vld       = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!vld && req[idx]) begin
        winner_oh[idx] = 1'b1;
        vld            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Shares one SHA-256 core among NUM_REQ requesters with round-robin fairness and a watchdog.
// Latency: req to core_start/grant 1 cycle; core_done to req_done 1 cycle; abort to next grant >= 3 cycles.
// Backpressure: requesters hold a level req until they see req_done or req_err; one job in flight at a time.
module sha256_core_arbiter
  import sha256_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_msg_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_out_addr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic                      busy,
  output logic [15:0]               jobs_done,
  output logic                      core_start,
  output logic [ADDR_W-1:0]         core_msg_addr,
  output logic [ADDR_W-1:0]         core_out_addr,
  input  logic                      core_done,
  output logic                      core_rst_n
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic                start_q, start_d;
  logic [ADDR_W-1:0]   msg_q, msg_d;
  logic [ADDR_W-1:0]   out_q, out_d;
  logic [15:0]         jobs_q, jobs_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic                rst_n_q, rst_n_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]   pick_msg;
  logic [ADDR_W-1:0]   pick_out;
  logic [PTR_W-1:0]    next_ptr;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req       (req),
    .ptr       (ptr_q),
    .winner_oh (pick_oh),
    .vld       (pick_vld)
  );

  // Turn the one-hot winner into an index and select its address slices.
  always_comb begin
    pick_idx = '0;
    pick_msg = '0;
    pick_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx = PTR_W'(i);
        pick_msg = req_msg_addr[i*ADDR_W +: ADDR_W];
        pick_out = req_out_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Priority moves to the requester just after the one that was served.
  assign next_ptr = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);

  // Next-state logic; the timer doubles as the recovery hold counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    msg_d   = msg_q;
    out_d   = out_q;
    jobs_d  = jobs_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    rst_n_d = rst_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_oh;
          win_d   = pick_idx;
          msg_d   = pick_msg;
          out_d   = pick_out;
          start_d = 1'b1;
          timer_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A done arriving on the timeout cycle still counts as success.
        if (core_done) begin
          done_d  = grant_q;
          jobs_d  = jobs_q + 16'd1;
          state_d = ST_RELEASE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          err_d   = grant_q;
          rst_n_d = 1'b0;
          timer_d = '0;
          state_d = ST_RECOVER;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        ptr_d   = next_ptr;
        state_d = ST_IDLE;
      end
      ST_RECOVER: begin
        if (timer_q == TMR_W'(CORE_RST_CYC - 1)) begin
          rst_n_d = 1'b1;
          grant_d = '0;
          ptr_d   = next_ptr;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight job silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      msg_q   <= '0;
      out_q   <= '0;
      jobs_q  <= '0;
      timer_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      rst_n_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      jobs_q  <= jobs_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
    end
  end

  assign grant         = grant_q;
  assign req_done      = done_q;
  assign req_err       = err_q;
  assign busy          = busy_q;
  assign jobs_done     = jobs_q;
  assign core_start    = start_q;
  assign core_msg_addr = msg_q;
  assign core_out_addr = out_q;
  assign core_rst_n    = rst_n_q;

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter: two instances (long and short watchdog) against a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sha256_core_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [3:0]  req_s   [2];
  logic [63:0] ma, oa;
  logic [1:0]  cd_v;
  int          lat     [2];
  int          cnt_e   [2];
  logic        chk_en;

  logic [3:0]  grant_w [2];
  logic [3:0]  done_w  [2];
  logic [3:0]  err_w   [2];
  logic        busy_w  [2];
  logic [15:0] jobs_w  [2];
  logic        start_w [2];
  logic [15:0] msg_w   [2];
  logic [15:0] out_w   [2];
  logic        rst_w   [2];

  int n_chk  = 0;
  int n_pass = 0;

  sha256_core_arbiter #(.NUM_REQ(4), .ADDR_W(16), .TIMEOUT_CYC(4096)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req_s[0]), .req_msg_addr(ma), .req_out_addr(oa),
    .grant(grant_w[0]), .req_done(done_w[0]), .req_err(err_w[0]), .busy(busy_w[0]),
    .jobs_done(jobs_w[0]), .core_start(start_w[0]), .core_msg_addr(msg_w[0]),
    .core_out_addr(out_w[0]), .core_done(cd_v[0]), .core_rst_n(rst_w[0]));

  sha256_core_arbiter #(.NUM_REQ(4), .ADDR_W(16), .TIMEOUT_CYC(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req(req_s[1]), .req_msg_addr(ma), .req_out_addr(oa),
    .grant(grant_w[1]), .req_done(done_w[1]), .req_err(err_w[1]), .busy(busy_w[1]),
    .jobs_done(jobs_w[1]), .core_start(start_w[1]), .core_msg_addr(msg_w[1]),
    .core_out_addr(out_w[1]), .core_done(cd_v[1]), .core_rst_n(rst_w[1]));

  // Behavioural model: st 0=idle 1=busy 2=release 3=recover, t counts cycles in the phase.
  typedef struct packed {
    int          st;
    int          ptr;
    int          win;
    int          t;
    int          jobs;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        start;
    logic [15:0] msg;
    logic [15:0] out;
    logic        rst_n;
    logic        busy;
  } mdl_t;

  mdl_t m [2];
  int   tmo [2] = '{4096, 16};

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r       = '0;
    r.rst_n = 1'b1;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t c, logic [3:0] rq, logic [63:0] a_msg,
                                    logic [63:0] a_out, logic cd, int limit);
    mdl_t n;
    int   w;
    n       = c;
    n.start = 1'b0;
    n.done  = '0;
    n.err   = '0;
    w       = -1;
    if (c.st == 0) begin
      for (int k = 0; k < 4; k++)
        if (w < 0 && rq[(c.ptr + k) % 4]) w = (c.ptr + k) % 4;
      if (w >= 0) begin
        n.st    = 1;
        n.win   = w;
        n.grant = 4'(1 << w);
        n.msg   = a_msg[w*16 +: 16];
        n.out   = a_out[w*16 +: 16];
        n.start = 1'b1;
        n.t     = 1;
      end
    end else if (c.st == 1) begin
      // c.t is the 1-based count of BUSY cycles spent so far.
      if (cd) begin
        n.done = 4'(1 << c.win);
        n.jobs = (c.jobs + 1) % 65536;
        n.st   = 2;
      end else if (c.t == limit) begin
        n.err   = 4'(1 << c.win);
        n.rst_n = 1'b0;
        n.st    = 3;
        n.t     = 1;
      end else begin
        n.t = c.t + 1;
      end
    end else if (c.st == 2) begin
      n.grant = '0;
      n.ptr   = (c.win + 1) % 4;
      n.st    = 0;
    end else begin
      if (c.t == 2) begin
        n.rst_n = 1'b1;
        n.grant = '0;
        n.ptr   = (c.win + 1) % 4;
        n.st    = 0;
      end else begin
        n.t = c.t + 1;
      end
    end
    n.busy = (n.st != 0);
    return n;
  endfunction

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) m[k] <= mdl_reset();
    end else begin
      for (int k = 0; k < 2; k++) m[k] <= mdl_step(m[k], req_s[k], ma, oa, cd_v[k], tmo[k]);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("i%0d.grant", k),     64'(grant_w[k]), 64'(m[k].grant));
        chk($sformatf("i%0d.req_done", k),  64'(done_w[k]),  64'(m[k].done));
        chk($sformatf("i%0d.req_err", k),   64'(err_w[k]),   64'(m[k].err));
        chk($sformatf("i%0d.busy", k),      64'(busy_w[k]),  64'(m[k].busy));
        chk($sformatf("i%0d.jobs_done", k), 64'(jobs_w[k]),  64'(m[k].jobs));
        chk($sformatf("i%0d.core_start", k), 64'(start_w[k]), 64'(m[k].start));
        chk($sformatf("i%0d.core_msg", k),  64'(msg_w[k]),   64'(m[k].msg));
        chk($sformatf("i%0d.core_out", k),  64'(out_w[k]),   64'(m[k].out));
        chk($sformatf("i%0d.core_rst_n", k), 64'(rst_w[k]),  64'(m[k].rst_n));
      end
    end
  end

  // Core stand-in: after a start, pulse done once lat ticks later (lat <= 0 means never).
  initial begin
    cd_v     = '0;
    cnt_e[0] = -1;
    cnt_e[1] = -1;
    forever begin
      tick();
      for (int k = 0; k < 2; k++) begin
        cd_v[k] = 1'b0;
        if (!reset_n) cnt_e[k] = -1;
        else if (cnt_e[k] > 0) begin
          cnt_e[k]--;
          if (cnt_e[k] == 0) cd_v[k] = 1'b1;
        end else if (start_w[k] && lat[k] > 0) cnt_e[k] = lat[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic saw_low, saw_err;
    reset_n  = 1'b1;
    req_s[0] = '0;
    req_s[1] = '0;
    lat[0]   = 0;
    lat[1]   = 0;
    chk_en   = 1'b0;
    ma = {16'h3A00, 16'h0000, 16'h1A00, 16'h0A00};
    oa = {16'h3B00, 16'h0100, 16'h1B00, 16'h0B00};
    #3 reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Reset values.
    chk("rst_grant", 64'(grant_w[0]), 64'h0);
    chk("rst_busy", 64'(busy_w[0]), 64'h0);
    chk("rst_core_rst_n", 64'(rst_w[0]), 64'h1);
    chk("rst_jobs", 64'(jobs_w[0]), 64'h0);

    // Single requester 2, core answers 150 cycles after start.
    lat[0]   = 150;
    req_s[0] = 4'b0100;
    cnt = 0;
    while (cnt < 10 && !start_w[0]) begin tick(); cnt++; end
    chk("t1_start_latency", 64'(cnt), 64'd1);
    chk("t1_grant", 64'(grant_w[0]), 64'h4);
    chk("t1_msg", 64'(msg_w[0]), 64'h0000);
    chk("t1_out", 64'(out_w[0]), 64'h0100);
    tick();
    chk("t1_start_one_cycle", 64'(start_w[0]), 64'h0);
    cnt = 1;
    while (cnt < 400 && !done_w[0][2]) begin tick(); cnt++; end
    chk("t1_done_latency", 64'(cnt), 64'd151);
    chk("t1_jobs", 64'(jobs_w[0]), 64'd1);
    req_s[0] = '0;
    tick();
    chk("t1_done_pulse", 64'(done_w[0]), 64'h0);
    chk("t1_busy_after", 64'(busy_w[0]), 64'h0);

    // Reset in the middle of a job; requester 3 waits and wins from ptr 0 afterwards.
    lat[0]   = 100;
    req_s[0] = 4'b0001;
    cnt = 0;
    while (cnt < 10 && !start_w[0]) begin tick(); cnt++; end
    chk("rs_start", 64'(grant_w[0]), 64'h1);
    repeat (5) tick();
    req_s[0] = 4'b1001;
    tick();
    reset_n = 1'b0;
    #1;
    chk("rs_grant", 64'(grant_w[0]), 64'h0);
    chk("rs_busy", 64'(busy_w[0]), 64'h0);
    chk("rs_jobs", 64'(jobs_w[0]), 64'h0);
    chk("rs_core_rst_n", 64'(rst_w[0]), 64'h1);
    req_s[0] = 4'b1000;
    tick();
    tick();
    lat[0]  = 5;
    reset_n = 1'b1;
    cnt = 0;
    while (cnt < 10 && !start_w[0]) begin tick(); cnt++; end
    chk("rs_first_latency", 64'(cnt), 64'd1);
    chk("rs_first_grant", 64'(grant_w[0]), 64'h8);
    chk("rs_first_msg", 64'(msg_w[0]), 64'h3A00);
    cnt = 0;
    while (cnt < 40 && !done_w[0][3]) begin tick(); cnt++; end
    chk("rs_done3", 64'(done_w[0][3]), 64'h1);
    req_s[0] = '0;
    tick();

    // Fresh reset, then all four requesting for eight jobs.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    lat[0]   = 3;
    req_s[0] = 4'hF;
    for (int n = 0; n < 8; n++) begin
      cnt = 0;
      while (cnt < 50 && !start_w[0]) begin tick(); cnt++; end
      chk($sformatf("rr_grant%0d", n), 64'(grant_w[0]), 64'(4'b0001 << (n % 4)));
      if (n == 7) req_s[0] = '0;
      tick();
    end
    cnt = 0;
    while (cnt < 50 && done_w[0] == 4'h0) begin tick(); cnt++; end
    chk("rr_last_done", 64'(done_w[0]), 64'h8);
    chk("rr_jobs", 64'(jobs_w[0]), 64'd8);
    tick();

    // Requester 1 drops req mid-job; its completion must still arrive.
    lat[0]   = 20;
    req_s[0] = 4'b0010;
    cnt = 0;
    while (cnt < 10 && !start_w[0]) begin tick(); cnt++; end
    chk("dr_grant", 64'(grant_w[0]), 64'h2);
    repeat (3) tick();
    req_s[0] = '0;
    cnt = 0;
    while (cnt < 60 && !done_w[0][1]) begin tick(); cnt++; end
    chk("dr_done1", 64'(done_w[0][1]), 64'h1);
    chk("dr_jobs", 64'(jobs_w[0]), 64'd9);

    // Watchdog on the 16-cycle instance: core never answers.
    lat[1]   = 0;
    req_s[1] = 4'b0001;
    cnt = 0;
    while (cnt < 10 && !start_w[1]) begin tick(); cnt++; end
    chk("to_grant", 64'(grant_w[1]), 64'h1);
    cnt = 0;
    while (cnt < 100 && !err_w[1][0]) begin tick(); cnt++; end
    chk("to_err_cycle", 64'(cnt), 64'd16);
    chk("to_err0", 64'(err_w[1]), 64'h1);
    req_s[1] = 4'b0010;
    lat[1]   = 15;
    cnt = 0;
    while (cnt < 10 && !rst_w[1]) begin cnt++; tick(); end
    chk("to_rst_low_cycles", 64'(cnt), 64'd2);
    chk("to_grant_cleared", 64'(grant_w[1]), 64'h0);
    while (cnt < 10 && !start_w[1]) begin tick(); cnt++; end
    chk("to_abort_to_grant", 64'(cnt), 64'd3);
    chk("to_next_grant", 64'(grant_w[1]), 64'h2);
    chk("to_jobs_unchanged", 64'(jobs_w[1]), 64'd0);

    // core_done lands on the last watchdog cycle: success wins.
    cnt     = 0;
    saw_low = 1'b0;
    saw_err = 1'b0;
    while (cnt < 100 && !done_w[1][1]) begin
      tick();
      cnt++;
      if (!rst_w[1]) saw_low = 1'b1;
      if (err_w[1] != 4'h0) saw_err = 1'b1;
    end
    req_s[1] = '0;
    chk("sim_done_cycle", 64'(cnt), 64'd16);
    chk("sim_no_rst", 64'(saw_low), 64'h0);
    chk("sim_no_err", 64'(saw_err), 64'h0);
    chk("sim_jobs", 64'(jobs_w[1]), 64'd1);
    repeat (4) tick();

    // Pin the model's own bookkeeping.
    chk("model_jobs0", 64'(m[0].jobs), 64'd9);
    chk("model_jobs1", 64'(m[1].jobs), 64'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
